// File: rtl/uart_echo_ctrl.sv
// UART echo controller: sends a power-on banner, then echoes received bytes
// through a small FIFO, with optional CR -> CR,LF expansion and banner replay.
module uart_echo_ctrl #(
  parameter int unsigned          MSG_LEN    = 13,
  parameter logic [MSG_LEN*8-1:0] BANNER     = "hellofpga.com",
  parameter int unsigned          FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  input  logic                          crlf_en,
  input  logic                          banner_req,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(MSG_LEN + 1);
  localparam int unsigned BW = 2 ** IW;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_BANNER = 2'd1;
  localparam logic [1:0] ST_ECHO   = 2'd2;
  localparam logic [1:0] ST_LF     = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          txv_q, txv_d;
  logic [7:0]    txd_q, txd_d;
  logic          lf_q, lf_d;
  logic          pend_q, pend_d;
  logic          busy_q;
  logic          ovf_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    ban_mem [BW];

  logic pop, push, drop, xfer, empty, full;
  logic [7:0] head;

  for (genvar i = 0; i < BW; i++) begin : g_ban
    if (i < MSG_LEN) begin : g_byte
      assign ban_mem[i] = BANNER[(MSG_LEN-1-i)*8 +: 8];
    end else begin : g_pad
      assign ban_mem[i] = '0;
    end
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_C);
  assign head  = mem_q[rd_q];
  assign xfer  = txv_q && tx_ready;
  assign push  = rx_valid && (!full || pop);
  assign drop  = rx_valid && !push;

  // The output register is only refilled on a cycle the transmitter is ready,
  // so a stalled transmitter leaves the whole backlog in the FIFO.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    txv_d   = txv_q;
    txd_d   = txd_q;
    lf_d    = lf_q;
    pend_d  = pend_q;
    pop     = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_BANNER;
        idx_d   = '0;
      end
      ST_BANNER: begin
        if (tx_ready) begin
          if (idx_q != LAST_IDX) begin
            txv_d = 1'b1;
            txd_d = ban_mem[idx_q];
            idx_d = idx_q + 1'b1;
          end else begin
            txv_d   = 1'b0;
            state_d = ST_ECHO;
          end
        end
      end
      ST_ECHO: begin
        pend_d = pend_q | banner_req;
        if (tx_ready) begin
          txv_d = 1'b0;
          if (xfer && lf_q) begin
            state_d = ST_LF;
            txv_d   = 1'b1;
            txd_d   = 8'h0A;
            lf_d    = 1'b0;
          end else if (pend_q) begin
            state_d = ST_BANNER;
            idx_d   = '0;
            pend_d  = 1'b0;
          end else if (!empty) begin
            pop   = 1'b1;
            txv_d = 1'b1;
            txd_d = head;
            lf_d  = crlf_en && (head == 8'h0D);
          end
        end
      end
      default: begin
        pend_d = pend_q | banner_req;
        if (xfer) begin
          txv_d   = 1'b0;
          state_d = ST_ECHO;
        end
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      lf_q    <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
      lf_q    <= lf_d;
      pend_q  <= pend_d;
      busy_q  <= (state_d == ST_BANNER);
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= rx_data;
  end

  assign tx_data    = txd_q;
  assign tx_valid   = txv_q;
  assign busy       = busy_q;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule
